cnt_sched: RTL

CNT_SCHED -- requirements
Module: cnt_sched

---
 rtl/cnt_sched_pkg.sv | 15 +
 rtl/cnt_sched_rr_arb.sv | 33 +++
 rtl/cnt_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cnt_sched_pkg.sv
// cnt_sched_pkg: shared definitions for the shared-counter scheduler.
//   - default requester count and counter width
//   - FSM state enumeration
package cnt_sched_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int W_DEF     = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/cnt_sched_rr_arb.sv
// rr_arb: combinational round-robin selector.
//   req     : request vector
//   ptr     : index where the search starts (wraps modulo N_REQ)
//   win     : one-hot winner, all-zero when no request
//   win_idx : binary index of the winner (0 when no request)
module rr_arb #(
   parameter int N_REQ = 4,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] win,
   output logic [IW-1:0]    win_idx
);

   logic w_hit;

   always_comb begin
      win     = '0;
      win_idx = '0;
      w_hit   = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         int j;
         j = (int'(ptr) + k) % N_REQ;
         if (!w_hit && req[j]) begin
            win[j]  = 1'b1;
            win_idx = IW'(j);
            w_hit   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cnt_sched.sv
// cnt_sched: one shared up-counter time-multiplexed among N_REQ requesters.
//   clk   : clock, rst : synchronous active-high reset
//   req   : per-requester request, held until done or abandoned
//   len   : per-requester terminal count, slice i = len[i*W +: W]
//   grant : one-hot current owner (registered)
//   done  : one-cycle one-hot completion pulse (registered)
//   busy  : high while counting (registered)
//   val   : current count (registered)
module cnt_sched
   import cnt_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W     = W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] len,
   output logic [N_REQ-1:0]   grant,
   output logic [N_REQ-1:0]   done,
   output logic               busy,
   output logic [W-1:0]       val
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t           r_state, w_state_nxt;
   logic [IW-1:0]    r_ptr, w_ptr_nxt;
   logic [IW-1:0]    r_idx, w_idx_nxt;
   logic [W-1:0]     r_len, w_len_nxt;
   logic [W-1:0]     r_val, w_val_nxt;
   logic [N_REQ-1:0] r_grant, w_grant_nxt;
   logic [N_REQ-1:0] r_done, w_done_nxt;
   logic             r_busy, w_busy_nxt;

   logic [N_REQ-1:0] w_win;
   logic [IW-1:0]    w_win_idx;
   logic             w_own_req;
   logic             w_at_end;
   logic [IW-1:0]    w_idx_inc;

   rr_arb #(.N_REQ(N_REQ), .IW(IW)) u_arb (
      .req     (req),
      .ptr     (r_ptr),
      .win     (w_win),
      .win_idx (w_win_idx)
   );

   assign w_own_req = req[r_idx];
   assign w_at_end  = (r_val == r_len);
   // pointer moves just past the finishing owner so it yields to others
   assign w_idx_inc = (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;

   // state register and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_idx   <= '0;
         r_len   <= '0;
         r_val   <= '0;
         r_grant <= '0;
         r_done  <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_idx   <= w_idx_nxt;
         r_len   <= w_len_nxt;
         r_val   <= w_val_nxt;
         r_grant <= w_grant_nxt;
         r_done  <= w_done_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // next-state
   always_comb begin
      w_state_nxt = ST_IDLE;
      case (r_state)
         ST_IDLE:  w_state_nxt = (|req) ? ST_COUNT : ST_IDLE;
         // an abandoned request wins over reaching the terminal count
         ST_COUNT: w_state_nxt = !w_own_req ? ST_IDLE :
                                 w_at_end   ? ST_DONE : ST_COUNT;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // next values of the registered outputs and datapath
   always_comb begin
      w_ptr_nxt   = r_ptr;
      w_idx_nxt   = r_idx;
      w_len_nxt   = r_len;
      w_val_nxt   = '0;
      w_grant_nxt = '0;
      w_done_nxt  = '0;
      w_busy_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|req) begin
               w_idx_nxt   = w_win_idx;
               w_len_nxt   = len[int'(w_win_idx)*W +: W];
               w_grant_nxt = w_win;
               w_busy_nxt  = 1'b1;
            end
         end
         ST_COUNT: begin
            if (!w_own_req) begin
               w_ptr_nxt = w_idx_inc;
            end else if (w_at_end) begin
               w_done_nxt = r_grant;
               w_val_nxt  = r_val;
               w_ptr_nxt  = w_idx_inc;
            end else begin
               w_grant_nxt = r_grant;
               w_busy_nxt  = 1'b1;
               w_val_nxt   = r_val + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign grant = r_grant;
   assign done  = r_done;
   assign busy  = r_busy;
   assign val   = r_val;

endmodule
